bram_dump_sequencer: RTL and testbench
======================================

Name: bram_dump_sequencer

Overview:
Synchronous controller that walks a BRAM address range, reads each word through the BRAM read port, and drives the serial_tx byte interface with an ASCII hex dump. It replaces the sendbyte-clocked stage logic with a single-clock FSM that has proper send/busy handshakes, a programmable range, line formatting, abort and completion status. It sits between the BRAM read port (SP, READ_MODE 0) and serial_tx, and is started by a debug or host trigger.

Parameters:
ADDR_W, 10, BRAM word-address width (1..16)
DATA_W, 8, BRAM data width dumped per word (multiple of 4, 4..16)
WORDS_PER_LINE, 16, words printed per text line (1..255)
RD_LAT, 1, cycles from bram_ad valid to bram_do valid (1 or 2)

Ports:
clk  in  1  system clock
RESET  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a dump when idle
abort  in  1  level or pulse; stops the dump at the next byte boundary
addr_start  in  ADDR_W  first word address, sampled on accepted start
addr_end  in  ADDR_W  last word address (inclusive), sampled on accepted start
bram_ad  out  ADDR_W  BRAM read address
bram_ce  out  1  BRAM read enable
bram_do  in  DATA_W  BRAM read data
tx_data  out  8  byte to serial_tx
tx_send  out  1  one-cycle send strobe to serial_tx
tx_busy  in  1  serial_tx busy
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of dump
aborted  out  1  valid with done: 1 = terminated by abort

Behaviour:
- Clock and reset: single clock; RESET is asynchronous and active-high. The clock port is clk and the reset port is RESET.
- Reset values: tx_send=0, tx_data=0, bram_ce=0, bram_ad=0, busy=0, done=0, aborted=0, FSM=IDLE. RESET mid-dump clears all state immediately. A partial line is not completed.
- start is accepted only in IDLE; it is ignored while busy=1. On acceptance, addr_start/addr_end are latched, busy goes high the next cycle, and cur_addr=addr_start.
- If latched addr_end < addr_start, no bytes are sent. done=1 and aborted=0 two cycles after start, then the FSM returns to IDLE.
- Line format (ASCII, uppercase hex, MSB nibble first):
  - '$', then 4 hex digits of the line's first address (zero-extended to 16 bits), then '#'.
  - For each word: DATA_W/4 hex digits followed by ' '.
  - The line ends with CR (0x0D) then LF (0x0A).
- A line closes after WORDS_PER_LINE words, or after the word at addr_end, whichever comes first.
- States: IDLE, HDR, ADDR (4 digits, nibble counter), SEP, RD_REQ, RD_WAIT, DIGIT (DATA_W/4 digits), SPACE, CR, LF, FIN.
- Read: RD_REQ drives bram_ad=cur_addr and bram_ce=1 for 1 cycle. RD_WAIT holds for RD_LAT cycles. bram_do is then captured into a shift register, and digits are taken from the shift register only.
- Byte handshake, applied to every emitted byte:
  - Wait while tx_busy=1.
  - Drive tx_data and pulse tx_send for exactly 1 cycle.
  - Ignore tx_busy in the following cycle (GUARD).
  - Then wait for tx_busy=0 before the next byte.
  - tx_data stays stable from the send cycle until the next send.
- Address advance: after a word's SPACE byte completes:
  - If cur_addr==addr_end, go to CR.
  - Otherwise cur_addr+1, and word counter +1.
  - If word counter hits WORDS_PER_LINE, go to CR; else go to RD_REQ.
  - After LF, go to HDR if not finished, else FIN.
  - cur_addr never wraps: addr_end = 2^ADDR_W-1 terminates normally.
- Abort: sampled every cycle while busy. An in-flight byte (send issued) completes its handshake. No further bytes are sent, no CR/LF is added, and the FSM goes to FIN with aborted=1. Abort in the same cycle as an accepted start is honoured: no bytes are sent, done=1 and aborted=1.
- FIN: done=1 and busy=0 for 1 cycle, then IDLE. aborted holds until the next accepted start.
- start arriving in the FIN cycle is ignored.

Test Plan:
- ADDR_W=10, DATA_W=8, WPL=16; mem[0]=0x45, mem[1]=0xC8; start 0x000..0x001 with an ideal tx model (busy 10 cycles) -> bytes "$0000#45 C8 \r\n" (14 sends), then done=1, aborted=0.
- Range 0x000..0x010 (17 words) -> line 1 "$0000#" + 16 words + CRLF; line 2 "$0010#" + 1 word + CRLF; done once.
- addr_start=0x005, addr_end=0x004 -> zero tx_send pulses; done=1 exactly 2 cycles after start.
- Range 0x3FF..0x3FF -> "$03FF#xx \r\n", then done; bram_ad never shows 0x000 after start.
- Abort asserted while the 2nd data digit is being sent -> that byte completes, no further tx_send, done=1, aborted=1; start ignored while busy.
- tx_busy held high 500 cycles before the first byte -> tx_send stays 0 until busy falls. Separately, RESET mid-ADDR -> all outputs return to reset values within the reset cycle, and a new start gives a correct full dump.

Source files
------------

// File: rtl/bram_dump_sequencer.sv
// BRAM hex-dump sequencer: walks an inclusive word-address range, reads each
// word and streams "$AAAA#DD DD ... \r\n" lines to a byte-wide serial
// transmitter using a send/busy handshake. Supports abort and completion status.
module bram_dump_sequencer #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 8,
  parameter int WORDS_PER_LINE = 16,
  parameter int RD_LAT         = 1
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] addr_start,
  input  logic [ADDR_W-1:0] addr_end,
  output logic [ADDR_W-1:0] bram_ad,
  output logic              bram_ce,
  input  logic [DATA_W-1:0] bram_do,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam logic [3:0] S_IDLE = 4'd0, S_HDR = 4'd1, S_ADDR = 4'd2, S_SEP = 4'd3,
                         S_RD_REQ = 4'd4, S_RD_WAIT = 4'd5, S_DIGIT = 4'd6,
                         S_SPACE = 4'd7, S_CR = 4'd8, S_LF = 4'd9, S_FIN = 4'd10;
  // Per-byte handshake phase inside every byte-emitting state.
  localparam logic [1:0] P_READY = 2'd0, P_SEND = 2'd1, P_GUARD = 2'd2, P_DRAIN = 2'd3;
  localparam logic [1:0] DIG_LAST = 2'(DATA_W/4 - 1);
  localparam logic [7:0] WPL_LAST = 8'(WORDS_PER_LINE - 1);
  localparam logic       LAT_LAST = 1'(RD_LAT - 1);

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  logic [3:0]        state_q, state_d;
  logic [1:0]        ph_q, ph_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] cur_q, cur_d, end_q, end_d;
  logic              empty_q, empty_d, last_q, last_d, lat_q, lat_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_send_q, tx_send_d;
  logic              abort_q, abort_d, aborted_q, aborted_d;
  logic [15:0]       a16;
  logic [7:0]        byte_c;
  logic              abort_now;

  assign abort_now = abort_q | abort;

  // Line address zero-extended to the 16 bits printed in the header.
  always_comb begin
    a16 = '0;
    a16[ADDR_W-1:0] = cur_q;
  end

  // Byte that the current emitting state would send.
  always_comb begin
    byte_c = 8'h20;
    case (state_q)
      S_HDR:   byte_c = 8'h24;
      S_ADDR:  byte_c = hexc(a16[{~cnt_q, 2'b00} +: 4]);
      S_SEP:   byte_c = 8'h23;
      S_DIGIT: byte_c = hexc(sh_q[DATA_W-1 -: 4]);
      S_CR:    byte_c = 8'h0D;
      S_LF:    byte_c = 8'h0A;
      default: byte_c = 8'h20;
    endcase
  end

  // Next-state logic: range walk, read sequencing and byte handshake.
  always_comb begin
    state_d   = state_q;   ph_d    = ph_q;    cnt_d  = cnt_q;   wcnt_d = wcnt_q;
    cur_d     = cur_q;     end_d   = end_q;   empty_d = empty_q; last_d = last_q;
    lat_d     = lat_q;     sh_d    = sh_q;    tx_data_d = tx_data_q;
    tx_send_d = 1'b0;      abort_d = abort_q; aborted_d = aborted_q;
    if (busy) abort_d = abort_q | abort;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_HDR;  ph_d = P_READY;  cur_d = addr_start;  end_d = addr_end;
        empty_d = (addr_end < addr_start);  last_d = 1'b0;  wcnt_d = '0;
        abort_d = abort;  aborted_d = 1'b0;
      end
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
        lat_d   = 1'b0;
      end
      S_RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          sh_d = bram_do;  cnt_d = '0;  state_d = S_DIGIT;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: begin
        case (ph_q)
          P_READY: begin
            if (abort_now) begin
              state_d = S_FIN;  aborted_d = 1'b1;
            end else if (state_q == S_HDR && empty_q) begin
              state_d = S_FIN;
            end else if (!tx_busy) begin
              tx_send_d = 1'b1;  tx_data_d = byte_c;  ph_d = P_SEND;
            end
          end
          P_SEND:  ph_d = P_GUARD;
          P_GUARD: ph_d = P_DRAIN;   // transmitter may not have raised busy yet
          default: if (!tx_busy) begin
            ph_d = P_READY;
            if (abort_now) begin
              state_d = S_FIN;  aborted_d = 1'b1;
            end else begin
              case (state_q)
                S_HDR:  begin state_d = S_ADDR; cnt_d = '0; end
                S_ADDR: if (cnt_q == 2'd3) state_d = S_SEP; else cnt_d = cnt_q + 1'b1;
                S_SEP:  state_d = S_RD_REQ;
                S_DIGIT: begin
                  sh_d = sh_q << 4;
                  if (cnt_q == DIG_LAST) state_d = S_SPACE; else cnt_d = cnt_q + 1'b1;
                end
                S_SPACE: begin
                  // Stop before incrementing so the top address never wraps.
                  if (cur_q == end_q) begin
                    last_d = 1'b1;  state_d = S_CR;
                  end else begin
                    cur_d = cur_q + 1'b1;
                    if (wcnt_q == WPL_LAST) begin
                      wcnt_d = '0;  state_d = S_CR;
                    end else begin
                      wcnt_d = wcnt_q + 1'b1;  state_d = S_RD_REQ;
                    end
                  end
                end
                S_CR:    state_d = S_LF;
                S_LF:    state_d = last_q ? S_FIN : S_HDR;
                default: state_d = S_IDLE;
              endcase
            end
          end
        endcase
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;  ph_q <= P_READY;  cnt_q <= '0;  wcnt_q <= '0;
      cur_q <= '0;  end_q <= '0;  empty_q <= 1'b0;  last_q <= 1'b0;  lat_q <= 1'b0;
      sh_q <= '0;  tx_data_q <= '0;  tx_send_q <= 1'b0;
      abort_q <= 1'b0;  aborted_q <= 1'b0;
    end else begin
      state_q <= state_d;  ph_q <= ph_d;  cnt_q <= cnt_d;  wcnt_q <= wcnt_d;
      cur_q <= cur_d;  end_q <= end_d;  empty_q <= empty_d;  last_q <= last_d;  lat_q <= lat_d;
      sh_q <= sh_d;  tx_data_q <= tx_data_d;  tx_send_q <= tx_send_d;
      abort_q <= abort_d;  aborted_q <= aborted_d;
    end
  end

  assign bram_ad = cur_q;
  assign bram_ce = (state_q == S_RD_REQ);
  assign tx_data = tx_data_q;
  assign tx_send = tx_send_q;
  assign busy    = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done    = (state_q == S_FIN);
  assign aborted = aborted_q;

endmodule

// File: tb/tb_bram_dump_sequencer.sv
// Bench for bram_dump_sequencer: BRAM and serial_tx models, a text-level
// reference model of the dump format, a vector table and corner sequences.
module tb_bram_dump_sequencer;
  localparam int AW = 10, DW = 8, WPL = 16, RD_LAT = 1;

  logic clk, RESET, start, abort, bram_ce, tx_send, tx_busy, busy, done, aborted;
  logic [AW-1:0] addr_start, addr_end, bram_ad;
  logic [DW-1:0] bram_do, d1, d2;
  logic [7:0]    tx_data;

  bram_dump_sequencer #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .RESET(RESET), .start(start), .abort(abort),
    .addr_start(addr_start), .addr_end(addr_end), .bram_ad(bram_ad), .bram_ce(bram_ce),
    .bram_do(bram_do), .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .busy(busy), .done(done), .aborted(aborted));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];
  logic [7:0] got_q[$], exp_q[$];
  int         ad_q[$], exp_ad[$];
  int n_chk = 0, n_err = 0;
  int cyc = 0, done_cnt = 0, done_edge = 0, st_edge = 0, viol = 0, bcnt = 0, blen = 10;
  logic last_ab = 1'b0, force_busy = 1'b0, send_d = 1'b0, rst_d = 1'b1;
  logic [7:0] data_d = 8'h00;

  // Synchronous-read BRAM with RD_LAT cycles of latency.
  always @(posedge clk) begin
    if (bram_ce) d1 <= mem[bram_ad];
    d2 <= d1;
  end
  assign bram_do = (RD_LAT == 1) ? d1 : d2;

  assign tx_busy = force_busy | (bcnt != 0);

  // Transmitter model and protocol monitor.
  always @(posedge clk) begin
    if (tx_send) begin
      got_q.push_back(tx_data);
      if (tx_busy) viol++;
      if (send_d) viol++;
    end
    if (!tx_send && !RESET && !rst_d && tx_data != data_d) viol++;
    if (bram_ce) ad_q.push_back(int'(bram_ad));
    if (done) begin done_cnt++; last_ab = aborted; done_edge = cyc; end
    if (tx_send) bcnt <= blen; else if (bcnt != 0) bcnt <= bcnt - 1;
    send_d = tx_send; data_d = tx_data; rst_d = RESET;
    cyc++;
  end

  task automatic chk(input string nm, input longint g, input longint x);
    n_chk++;
    if (g !== x) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, g, g, x, x);
    end
  endtask

  function automatic logic [7:0] hx(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  // Reference: the text the dump should produce, built line by line.
  function automatic void build_exp(input int s, input int e);
    int a;
    exp_q.delete(); exp_ad.delete();
    if (e < s) return;
    a = s;
    forever begin
      exp_q.push_back("$");
      for (int k = 3; k >= 0; k--) exp_q.push_back(hx((a >> (4*k)) & 15));
      exp_q.push_back("#");
      for (int w = 0; w < WPL; w++) begin
        exp_ad.push_back(a);
        exp_q.push_back(hx(int'(mem[a]) >> 4));
        exp_q.push_back(hx(int'(mem[a]) & 15));
        exp_q.push_back(" ");
        if (a == e) begin exp_q.push_back(8'h0D); exp_q.push_back(8'h0A); return; end
        a++;
      end
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    end
  endfunction

  task automatic clear();
    got_q.delete(); ad_q.delete(); done_cnt = 0; viol = 0; last_ab = 1'b0;
  endtask

  task automatic do_start(input int s, input int e, input logic ab);
    addr_start = AW'(s); addr_end = AW'(e); abort = ab; start = 1'b1; st_edge = cyc;
    @(negedge clk); start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin @(negedge clk); n++; end
    chk($sformatf("%s done seen", nm), done_cnt > 0, 1);
  endtask

  task automatic finish_run(input string nm, input int s, input int e, input int nsend);
    int bad = -1, bada = -1;
    wait_done(nm, 20000);
    repeat (3) @(negedge clk);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && got_q[i] != exp_q[i]) bad = i;
    for (int i = 0; i < ad_q.size() && i < exp_ad.size(); i++)
      if (bada < 0 && ad_q[i] != exp_ad[i]) bada = i;
    if (nsend >= 0) chk($sformatf("%s send count", nm), got_q.size(), nsend);
    chk($sformatf("%s bytes vs model", nm), got_q.size(), exp_q.size());
    chk($sformatf("%s first bad byte index", nm), bad, -1);
    chk($sformatf("%s bram reads vs model", nm), ad_q.size(), exp_ad.size());
    chk($sformatf("%s first bad read index", nm), bada, -1);
    chk($sformatf("%s done pulses", nm), done_cnt, 1);
    chk($sformatf("%s aborted", nm), last_ab, 0);
    chk($sformatf("%s handshake violations", nm), viol, 0);
    if (e < s) chk($sformatf("%s empty done latency", nm), done_edge - st_edge, 2);
  endtask

  task automatic run_std(input string nm, input int s, input int e, input int bl, input int nsend);
    build_exp(s, e); clear(); blen = bl;
    do_start(s, e, 1'b0);
    finish_run(nm, s, e, nsend);
  endtask

  typedef struct { int s; int e; int bl; int nsend; } vec_t;
  vec_t tbl[6];

  initial begin
    string lit;
    int bad, n, s, e;
    RESET = 1'b1; start = 1'b0; abort = 1'b0; addr_start = '0; addr_end = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h45; mem[1] = 8'hC8;
    tbl[0] = '{16'h000, 16'h010, 10, 67};
    tbl[1] = '{16'h005, 16'h004, 10, 0};
    tbl[2] = '{16'h3FF, 16'h3FF, 10, 11};
    tbl[3] = '{16'h020, 16'h02F, 2, 56};
    tbl[4] = '{16'h3F0, 16'h3FF, 0, 56};
    tbl[5] = '{16'h100, 16'h120, 4, 123};

    #1;
    chk("reset outputs", {tx_send, tx_data, bram_ce, bram_ad, busy, done, aborted}, 0);
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    @(negedge clk);

    // Two-word dump against the literal line.
    run_std("two words", 0, 1, 10, 14);
    lit = "$0000#45 C8 \r\n";
    bad = -1;
    for (int i = 0; i < lit.len() && i < got_q.size(); i++)
      if (bad < 0 && got_q[i] != lit[i]) bad = i;
    chk("two words literal first bad index", bad, -1);

    for (int v = 0; v < 6; v++)
      run_std($sformatf("vec%0d", v), tbl[v].s, tbl[v].e, tbl[v].bl, tbl[v].nsend);

    for (int r = 0; r < 12; r++) begin
      s = $urandom_range(0, 1023);
      if (r % 5 == 4 && s > 0) e = $urandom_range(0, s - 1);
      else e = (s + $urandom_range(0, 40) > 1023) ? 1023 : s + $urandom_range(0, 40);
      run_std($sformatf("rand%0d", r), s, e, $urandom_range(0, 6), -1);
    end

    // Abort during the second data digit; concurrent start must be ignored.
    build_exp(16'h40, 16'h4F); clear(); blen = 6;
    do_start(16'h40, 16'h4F, 1'b0);
    n = 0;
    while (got_q.size() < 8 && n < 5000) begin @(negedge clk); n++; end
    chk("abort reached 8th byte", got_q.size(), 8);
    chk("abort 8th byte is 2nd digit", got_q[7], exp_q[7]);
    abort = 1'b1; start = 1'b1; addr_start = '0; addr_end = '1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    wait_done("abort", 5000);
    repeat (30) @(negedge clk);
    chk("abort no further sends", got_q.size(), 8);
    chk("abort done pulses", done_cnt, 1);
    chk("abort flag with done", last_ab, 1);
    chk("abort idle after", busy, 0);
    chk("abort flag holds", aborted, 1);
    chk("abort handshake violations", viol, 0);

    // Abort together with start.
    clear();
    do_start(5, 20, 1'b1);
    wait_done("abort at start", 100);
    repeat (3) @(negedge clk);
    chk("abort at start sends", got_q.size(), 0);
    chk("abort at start latency", done_edge - st_edge, 2);
    chk("abort at start flag", last_ab, 1);

    // Transmitter busy for 500 cycles before the first byte.
    build_exp(0, 1); clear(); blen = 10; force_busy = 1'b1;
    do_start(0, 1, 1'b0);
    repeat (500) @(negedge clk);
    chk("held busy no send", got_q.size(), 0);
    chk("held busy dut busy", busy, 1);
    force_busy = 1'b0;
    finish_run("held busy", 0, 1, 14);

    // Reset while the header address digits are going out.
    clear(); blen = 3;
    do_start(0, 16, 1'b0);
    n = 0;
    while (got_q.size() < 2 && n < 2000) begin @(negedge clk); n++; end
    chk("reset test reached ADDR", got_q.size(), 2);
    RESET = 1'b1;
    #1;
    chk("reset mid-ADDR outputs", {tx_send, tx_data, bram_ce, bram_ad, busy, done, aborted}, 0);
    @(negedge clk);
    RESET = 1'b0;
    @(negedge clk);
    run_std("after reset", 0, 16, 3, 67);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
